// File: rtl/c_tile_drain.sv
// c_tile_drain
//   Walks the flat C result tile row-major. Each element is streamed out over
//   a valid/ready port and is also written into a local result SRAM (c_mem)
//   that the CPU reads back with one cycle of latency.
//
// Ports
//   clk, rst              clock; synchronous active-high reset
//   start                 one-cycle pulse, begins a drain (ignored while busy)
//   row_len, col_len      drain extent, latched on start, clamped to M / N
//   busy, done            drain in progress / one-cycle completion pulse
//   C_tile_flat           element (r,n) at bit offset (r*N+n)*DATA_W
//   out_valid/out_ready   stream handshake: a beat moves on a clock edge where
//                         both are high; once valid rises, the beat
//                         (data/row/n/last) holds until it is accepted
//   out_data/out_row/out_n/out_last   beat payload
//   cpu_c_re/row/n        CPU read request
//   cpu_c_rdata/rvalid    read response, one cycle after the request
module c_tile_drain #(
    parameter int M      = 8,
    parameter int N      = 8,
    parameter int DATA_W = 32,
    parameter int ROW_W  = (M <= 1) ? 1 : $clog2(M),
    parameter int N_W    = (N <= 1) ? 1 : $clog2(N)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [ROW_W:0]           row_len,
    input  logic [N_W:0]             col_len,
    output logic                     busy,
    output logic                     done,
    input  logic [M*N*DATA_W-1:0]    C_tile_flat,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [ROW_W-1:0]         out_row,
    output logic [N_W-1:0]           out_n,
    output logic                     out_last,
    input  logic                     cpu_c_re,
    input  logic [ROW_W-1:0]         cpu_c_row,
    input  logic [N_W-1:0]           cpu_c_n,
    output logic [DATA_W-1:0]        cpu_c_rdata,
    output logic                     cpu_c_rvalid
);

    typedef enum logic [1:0] {IDLE, DRAIN, FIN} state_t;

    localparam logic [ROW_W:0] ROW_MAX = (ROW_W+1)'(M);
    localparam logic [N_W:0]   COL_MAX = (N_W+1)'(N);

    state_t           state;
    logic [ROW_W:0]   row_q;
    logic [N_W:0]     col_q;

    logic [ROW_W:0]   row_len_c;
    logic [N_W:0]     col_len_c;
    logic             col_wrap;
    logic [ROW_W-1:0] nxt_row;
    logic [N_W-1:0]   nxt_n;
    logic             nxt_last;
    logic             accept;

    logic [DATA_W-1:0] c_mem [M][N];

    function automatic logic [DATA_W-1:0] elem(input logic [ROW_W-1:0] r,
                                               input logic [N_W-1:0]   n);
        int idx;
        idx = int'(r) * N + int'(n);
        return C_tile_flat[idx*DATA_W +: DATA_W];
    endfunction

    // Out-of-range lengths are clamped to the physical tile size.
    assign row_len_c = (row_len > ROW_MAX) ? ROW_MAX : row_len;
    assign col_len_c = (col_len > COL_MAX) ? COL_MAX : col_len;

    // Index of the beat that follows the one currently presented.
    assign col_wrap = ({1'b0, out_n} == col_q - 1'b1);
    assign nxt_row  = col_wrap ? out_row + 1'b1 : out_row;
    assign nxt_n    = col_wrap ? '0 : out_n + 1'b1;
    assign nxt_last = ({1'b0, nxt_row} == row_q - 1'b1) &&
                      ({1'b0, nxt_n}   == col_q - 1'b1);

    assign accept = (state == DRAIN) && out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            row_q     <= '0;
            col_q     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            out_row   <= '0;
            out_n     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        row_q <= row_len_c;
                        col_q <= col_len_c;
                        busy  <= 1'b1;
                        if (row_len_c == '0 || col_len_c == '0) begin
                            // Empty drain: no beats, straight to completion.
                            state <= FIN;
                            done  <= 1'b1;
                        end else begin
                            state     <= DRAIN;
                            out_valid <= 1'b1;
                            out_row   <= '0;
                            out_n     <= '0;
                            out_data  <= elem('0, '0);
                            out_last  <= (row_len_c == 1) && (col_len_c == 1);
                        end
                    end
                end
                DRAIN: begin
                    if (accept) begin
                        if (out_last) begin
                            state     <= FIN;
                            out_valid <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            out_row  <= nxt_row;
                            out_n    <= nxt_n;
                            out_data <= elem(nxt_row, nxt_n);
                            out_last <= nxt_last;
                        end
                    end
                end
                FIN: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Result SRAM: not reset; written only by accepted beats.
    always_ff @(posedge clk) begin
        if (!rst && accept) begin
            c_mem[out_row][out_n] <= out_data;
        end
    end

    // CPU read port: a read colliding with a drain write sees the old word.
    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_c_rvalid <= 1'b0;
            cpu_c_rdata  <= '0;
        end else begin
            cpu_c_rvalid <= cpu_c_re;
            if (cpu_c_re) begin
                cpu_c_rdata <= c_mem[cpu_c_row][cpu_c_n];
            end
        end
    end

endmodule

// File: tb/tb_c_tile_drain.sv
module tb_c_tile_drain;

    localparam int M = 8;
    localparam int N = 8;
    localparam int DW = 32;

    logic            clk;
    logic            rst;
    logic            start;
    logic [3:0]      row_len;
    logic [3:0]      col_len;
    logic            busy;
    logic            done;
    logic [M*N*DW-1:0] C_tile_flat;
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   out_data;
    logic [2:0]      out_row;
    logic [2:0]      out_n;
    logic            out_last;
    logic            cpu_c_re;
    logic [2:0]      cpu_c_row;
    logic [2:0]      cpu_c_n;
    logic [DW-1:0]   cpu_c_rdata;
    logic            cpu_c_rvalid;

    c_tile_drain #(.M(M), .N(N), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .row_len(row_len), .col_len(col_len),
        .busy(busy), .done(done), .C_tile_flat(C_tile_flat),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_row(out_row), .out_n(out_n), .out_last(out_last),
        .cpu_c_re(cpu_c_re), .cpu_c_row(cpu_c_row), .cpu_c_n(cpu_c_n),
        .cpu_c_rdata(cpu_c_rdata), .cpu_c_rvalid(cpu_c_rvalid)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Beat = {last, row, n, data}
    logic [38:0] exp_q[$];
    logic [DW-1:0] tile_m [M][N];
    logic [DW-1:0] mem_m  [M][N];

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals();
        chk("rst_busy",   64'(busy), 64'd0);
        chk("rst_done",   64'(done), 64'd0);
        chk("rst_valid",  64'(out_valid), 64'd0);
        chk("rst_last",   64'(out_last), 64'd0);
        chk("rst_data",   64'(out_data), 64'd0);
        chk("rst_row",    64'(out_row), 64'd0);
        chk("rst_n",      64'(out_n), 64'd0);
        chk("rst_rvalid", 64'(cpu_c_rvalid), 64'd0);
        chk("rst_rdata",  64'(cpu_c_rdata), 64'd0);
    endtask

    // Fill the tile (pattern or random) and drive it onto C_tile_flat.
    task automatic load_tile(input bit pattern);
        for (int r = 0; r < M; r++) begin
            for (int n = 0; n < N; n++) begin
                tile_m[r][n] = pattern ? (32'hC000_0000 + (r << 16) + n) : $urandom;
                C_tile_flat[(r*N+n)*DW +: DW] = tile_m[r][n];
            end
        end
    endtask

    // Pipelined read of every address, one request per cycle.
    task automatic read_all();
        for (int r = 0; r < M; r++) begin
            for (int n = 0; n < N; n++) begin
                cpu_c_re  = 1'b1;
                cpu_c_row = 3'(r);
                cpu_c_n   = 3'(n);
                tick();
                chk("rd_valid", 64'(cpu_c_rvalid), 64'd1);
                chk($sformatf("rd_data_%0d_%0d", r, n), 64'(cpu_c_rdata), 64'(mem_m[r][n]));
            end
        end
        cpu_c_re = 1'b0;
        tick();
        chk("rd_valid_drop", 64'(cpu_c_rvalid), 64'd0);
    endtask

    // One drain. stall_pct: chance (%) of out_ready=0 per cycle.
    // rst_after: reset once this many beats are accepted (-1 = never).
    // restart_k: cycle index at which a spurious start is pulsed mid-drain.
    // rd01: keep reading address (0,1) throughout the drain.
    task automatic run_drain(input int rl, input int cl, input int stall_pct,
                             input int rst_after, input int restart_k, input bit rd01);
        int R, C, k, s, accepted, done_k;
        bit rdy;
        logic [DW-1:0] rd_exp;
        logic [38:0] b;

        R = (rl > M) ? M : rl;
        C = (cl > N) ? N : cl;
        exp_q.delete();
        for (int r = 0; r < R; r++)
            for (int n = 0; n < C; n++)
                exp_q.push_back({(r == R-1 && n == C-1), 3'(r), 3'(n), tile_m[r][n]});

        row_len   = 4'(rl);
        col_len   = 4'(cl);
        start     = 1'b1;
        out_ready = 1'b0;
        cpu_c_re  = rd01;
        cpu_c_row = 3'd0;
        cpu_c_n   = 3'd1;
        rd_exp    = mem_m[0][1];
        tick();
        start = 1'b0;
        k = 0; s = 0; accepted = 0; done_k = -1;

        while (k < 2000) begin
            if (rd01) begin
                chk("rd01_valid", 64'(cpu_c_rvalid), 64'd1);
                chk("rd01_data", 64'(cpu_c_rdata), 64'(rd_exp));
            end
            if (done) begin
                done_k = k;
                break;
            end
            chk("busy_drain", 64'(busy), 64'd1);
            chk("valid_drain", 64'(out_valid), 64'd1);
            if (exp_q.size() > 0)
                chk($sformatf("beat_%0d", accepted),
                    64'({out_last, out_row, out_n, out_data}), 64'(exp_q[0]));
            else
                chk("beat_extra", 64'(out_valid), 64'd0);

            if (rst_after >= 0 && accepted == rst_after) begin
                out_ready = 1'b0;
                rst = 1'b1;
                tick();
                rst = 1'b0;
                chk_reset_vals();
                for (int i = 0; i < 3; i++) begin
                    tick();
                    chk("no_done_after_rst", 64'(done), 64'd0);
                    chk("idle_after_rst", 64'(busy), 64'd0);
                end
                exp_q.delete();
                return;
            end

            rdy = ($urandom_range(99) >= stall_pct);
            out_ready = rdy;
            if (k == restart_k) begin
                start   = 1'b1;
                row_len = 4'($urandom_range(1, 8));
                col_len = 4'($urandom_range(1, 8));
            end
            rd_exp = mem_m[0][1];
            tick();
            start = 1'b0;
            k++;
            if (rdy) begin
                if (exp_q.size() > 0) begin
                    b = exp_q.pop_front();
                    mem_m[b[37:35]][b[34:32]] = b[31:0];
                end
                accepted++;
            end else begin
                s++;
            end
        end

        if (done_k < 0) begin
            chk("drain_timeout", 64'(done), 64'd1);
        end else begin
            chk("done_cycle", 64'(done_k), 64'(R*C + s));
            chk("done_busy", 64'(busy), 64'd1);
            chk("done_valid", 64'(out_valid), 64'd0);
            chk("beats_left", 64'(exp_q.size()), 64'd0);
            chk("beats_accepted", 64'(accepted), 64'(R*C));
        end

        // A start during the done cycle is still ignored.
        if (restart_k >= 0) begin
            start   = 1'b1;
            row_len = 4'd4;
            col_len = 4'd4;
        end
        cpu_c_re  = 1'b0;
        out_ready = 1'b0;
        tick();
        start = 1'b0;
        chk("post_busy", 64'(busy), 64'd0);
        chk("post_done", 64'(done), 64'd0);
        chk("post_valid", 64'(out_valid), 64'd0);
        tick();
        chk("post_idle", 64'(busy), 64'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst = 1'b1; start = 1'b0; row_len = '0; col_len = '0;
        out_ready = 1'b0; cpu_c_re = 1'b0; cpu_c_row = '0; cpu_c_n = '0;
        C_tile_flat = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals();
        rst = 1'b0;
        tick();

        // Full 8x8 drain with the fixed pattern, no stall.
        load_tile(1'b1);
        run_drain(8, 8, 0, -1, -1, 1'b0);
        read_all();

        // Backpressure with a start pulsed mid-drain.
        load_tile(1'b0);
        run_drain(8, 8, 40, -1, 5, 1'b0);
        read_all();

        // Partial tile: cells outside 3x5 keep previous values.
        load_tile(1'b0);
        run_drain(3, 5, 20, -1, -1, 1'b0);
        read_all();

        // Zero-length drains, with a start during the done cycle.
        run_drain(0, 5, 0, -1, 0, 1'b0);
        run_drain(6, 0, 0, -1, 0, 1'b0);

        // Oversized row length clamps to M.
        load_tile(1'b0);
        run_drain(15, 2, 0, -1, -1, 1'b0);

        // Continuous reads of (0,1) across its overwrite.
        load_tile(1'b0);
        run_drain(8, 8, 30, -1, -1, 1'b1);

        // Reset after 10 accepted beats, then a fresh drain.
        load_tile(1'b0);
        run_drain(8, 8, 0, 10, -1, 1'b0);
        read_all();
        load_tile(1'b0);
        run_drain(4, 8, 25, -1, -1, 1'b0);
        read_all();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
